// File: rtl/axi_lite_buffer_if.sv
// AXI-Lite channel bundle shared by an upstream master and a downstream slave.
//   master modport : drives AW/W/AR request channels and B/R ready
//   slave  modport : drives AW/W/AR ready and the B/R response channels
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;

  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, input aw_ready,
    output w_valid, w_data, w_strb, input w_ready,
    input b_valid, b_resp, output b_ready,
    output ar_valid, ar_addr, ar_prot, input ar_ready,
    input r_valid, r_data, r_resp, output r_ready
  );

  modport slave (
    input aw_valid, aw_addr, aw_prot, output aw_ready,
    input w_valid, w_data, w_strb, output w_ready,
    output b_valid, b_resp, input b_ready,
    input ar_valid, ar_addr, ar_prot, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready
  );
endinterface

// File: rtl/axi_lite_buffer.sv
// AXI-Lite buffer: one FIFO per channel (depth 0 = wire-through) plus
// write/read outstanding-transaction limiters gating address acceptance.
//   clk    : single clock for both sides
//   rstn   : asynchronous active-low reset
//   slave  : upstream side (this block is the slave)
//   master : downstream side (this block is the master)

// Circular-buffer FIFO. in_ready depends only on the registered count, so
// there is no combinational path from out_ready to in_ready. A full FIFO
// refuses a push even when it is popped in the same cycle.
module axi_lite_buffer_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rstn;
    assign out_valid      = in_valid;
    assign in_ready       = out_ready;
    assign out_data       = in_data;
  end else begin : g_fifo
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Pointers wrap explicitly so DEPTH need not be a power of two.
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end

    // Payload storage needs no reset; contents are only visible when count != 0.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
    end
  end
endmodule

module axi_lite_buffer #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter bit RELAX_CHECK        = 1'b0,
  parameter int AW_DEPTH           = 2,
  parameter int W_DEPTH            = 2,
  parameter int B_DEPTH            = 2,
  parameter int AR_DEPTH           = 2,
  parameter int R_DEPTH            = 2,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic           clk,
  input  logic           rstn,
  axi_lite_channel.slave  slave,
  axi_lite_channel.master master
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (AW_DEPTH < 0 || AW_DEPTH > 16) begin : g_bad_aw $fatal(1, "AW_DEPTH outside 0..16"); end
  if (W_DEPTH  < 0 || W_DEPTH  > 16) begin : g_bad_w  $fatal(1, "W_DEPTH outside 0..16");  end
  if (B_DEPTH  < 0 || B_DEPTH  > 16) begin : g_bad_b  $fatal(1, "B_DEPTH outside 0..16");  end
  if (AR_DEPTH < 0 || AR_DEPTH > 16) begin : g_bad_ar $fatal(1, "AR_DEPTH outside 0..16"); end
  if (R_DEPTH  < 0 || R_DEPTH  > 16) begin : g_bad_r  $fatal(1, "R_DEPTH outside 0..16");  end
  if (MAX_WR_OUTSTANDING < 1 || MAX_WR_OUTSTANDING > 255) begin : g_bad_mw
    $fatal(1, "MAX_WR_OUTSTANDING outside 1..255");
  end
  if (MAX_RD_OUTSTANDING < 1 || MAX_RD_OUTSTANDING > 255) begin : g_bad_mr
    $fatal(1, "MAX_RD_OUTSTANDING outside 1..255");
  end
  if (!RELAX_CHECK && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH must be 32 or 64");
  end
  if (RELAX_CHECK && (DATA_WIDTH < 8 || DATA_WIDTH > 1024 ||
                      (DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_dwr
    $fatal(1, "DATA_WIDTH must be a power of 2 in 8..1024");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
  } ax_pack_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } w_pack_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } r_pack_t;

  ax_pack_t   aw_in, aw_out, ar_in, ar_out;
  w_pack_t    w_in, w_out;
  r_pack_t    r_in, r_out;
  logic [1:0] b_out;

  logic aw_in_valid, aw_in_ready, aw_out_valid;
  logic ar_in_valid, ar_in_ready, ar_out_valid;
  logic w_out_valid, b_out_valid, r_out_valid;

  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       wr_open, rd_open;
  logic       aw_hs, b_hs, ar_hs, r_hs;

  // Limiters: address beats are held off (valid gated into the FIFO, ready
  // gated towards upstream) while the in-flight count sits at its cap.
  assign wr_open = (wr_cnt_q != 8'(MAX_WR_OUTSTANDING));
  assign rd_open = (rd_cnt_q != 8'(MAX_RD_OUTSTANDING));

  assign aw_in_valid    = slave.aw_valid && wr_open;
  assign slave.aw_ready = aw_in_ready && wr_open;
  assign ar_in_valid    = slave.ar_valid && rd_open;
  assign slave.ar_ready = ar_in_ready && rd_open;

  assign aw_hs = slave.aw_valid && slave.aw_ready;
  assign b_hs  = slave.b_valid  && slave.b_ready;
  assign ar_hs = slave.ar_valid && slave.ar_ready;
  assign r_hs  = slave.r_valid  && slave.r_ready;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    // A response with nothing outstanding is a protocol violation; hold at 0.
    if (aw_hs && !b_hs)                          wr_cnt_d = wr_cnt_q + 8'd1;
    else if (!aw_hs && b_hs && wr_cnt_q != 8'd0) wr_cnt_d = wr_cnt_q - 8'd1;
    if (ar_hs && !r_hs)                          rd_cnt_d = rd_cnt_q + 8'd1;
    else if (!ar_hs && r_hs && rd_cnt_q != 8'd0) rd_cnt_d = rd_cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  a_wr_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(b_hs && !aw_hs && wr_cnt_q == 8'd0));
  a_rd_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(r_hs && !ar_hs && rd_cnt_q == 8'd0));

  assign aw_in = {slave.aw_addr, slave.aw_prot};
  assign ar_in = {slave.ar_addr, slave.ar_prot};
  assign w_in  = {slave.w_data, slave.w_strb};
  assign r_in  = {master.r_data, master.r_resp};

  axi_lite_buffer_fifo #(.WIDTH($bits(ax_pack_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(aw_in_valid), .in_ready(aw_in_ready), .in_data(aw_in),
    .out_valid(aw_out_valid), .out_ready(master.aw_ready), .out_data(aw_out)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(w_pack_t)), .DEPTH(W_DEPTH)) u_w_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(slave.w_valid), .in_ready(slave.w_ready), .in_data(w_in),
    .out_valid(w_out_valid), .out_ready(master.w_ready), .out_data(w_out)
  );

  axi_lite_buffer_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(master.b_valid), .in_ready(master.b_ready), .in_data(master.b_resp),
    .out_valid(b_out_valid), .out_ready(slave.b_ready), .out_data(b_out)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(ax_pack_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(ar_in_valid), .in_ready(ar_in_ready), .in_data(ar_in),
    .out_valid(ar_out_valid), .out_ready(master.ar_ready), .out_data(ar_out)
  );

  axi_lite_buffer_fifo #(.WIDTH($bits(r_pack_t)), .DEPTH(R_DEPTH)) u_r_fifo (
    .clk(clk), .rstn(rstn),
    .in_valid(master.r_valid), .in_ready(master.r_ready), .in_data(r_in),
    .out_valid(r_out_valid), .out_ready(slave.r_ready), .out_data(r_out)
  );

  assign master.aw_valid = aw_out_valid;
  assign master.aw_addr  = aw_out.addr;
  assign master.aw_prot  = aw_out.prot;
  assign master.w_valid  = w_out_valid;
  assign master.w_data   = w_out.data;
  assign master.w_strb   = w_out.strb;
  assign slave.b_valid   = b_out_valid;
  assign slave.b_resp    = b_out;
  assign master.ar_valid = ar_out_valid;
  assign master.ar_addr  = ar_out.addr;
  assign master.ar_prot  = ar_out.prot;
  assign slave.r_valid   = r_out_valid;
  assign slave.r_data    = r_out.data;
  assign slave.r_resp    = r_out.resp;
endmodule

// File: tb/tb_axi_lite_buffer.sv
module tb_axi_lite_buffer;
  logic clk;
  logic rstn;
  int   total;
  int   bad;

  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_up ();
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_dn ();
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_up ();
  axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b_dn ();

  // Buffered instance: AW deep enough for the reset test, AR/R depth 3.
  axi_lite_buffer #(
    .AW_DEPTH(4), .W_DEPTH(2), .B_DEPTH(2), .AR_DEPTH(3), .R_DEPTH(3),
    .MAX_WR_OUTSTANDING(4), .MAX_RD_OUTSTANDING(4)
  ) dut_a (.clk(clk), .rstn(rstn), .slave(a_up), .master(a_dn));

  // Wire-through instance with a tight read limit.
  axi_lite_buffer #(
    .AW_DEPTH(0), .W_DEPTH(0), .B_DEPTH(0), .AR_DEPTH(0), .R_DEPTH(0),
    .MAX_WR_OUTSTANDING(4), .MAX_RD_OUTSTANDING(2)
  ) dut_b (.clk(clk), .rstn(rstn), .slave(b_up), .master(b_dn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_up.aw_valid = 0; a_up.aw_addr = '0; a_up.aw_prot = '0;
    a_up.w_valid = 0; a_up.w_data = '0; a_up.w_strb = '0; a_up.b_ready = 0;
    a_up.ar_valid = 0; a_up.ar_addr = '0; a_up.ar_prot = '0; a_up.r_ready = 0;
    a_dn.aw_ready = 0; a_dn.w_ready = 0; a_dn.b_valid = 0; a_dn.b_resp = '0;
    a_dn.ar_ready = 0; a_dn.r_valid = 0; a_dn.r_data = '0; a_dn.r_resp = '0;
    b_up.aw_valid = 0; b_up.aw_addr = '0; b_up.aw_prot = '0;
    b_up.w_valid = 0; b_up.w_data = '0; b_up.w_strb = '0; b_up.b_ready = 0;
    b_up.ar_valid = 0; b_up.ar_addr = '0; b_up.ar_prot = '0; b_up.r_ready = 0;
    b_dn.aw_ready = 0; b_dn.w_ready = 0; b_dn.b_valid = 0; b_dn.b_resp = '0;
    b_dn.ar_ready = 0; b_dn.r_valid = 0; b_dn.r_data = '0; b_dn.r_resp = '0;
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    int ar_sent, ar_acc, r_sent, r_recv;
    logic hs_ar_up, hs_ar_dn, hs_r_dn, hs_r_up;
    total = 0;
    bad   = 0;
    rstn  = 1'b1;
    idle_all();
    #1 rstn = 1'b0;
    #2;

    // Reset state
    chk("rst_a_aw_ready", a_up.aw_ready, 1);
    chk("rst_a_w_ready",  a_up.w_ready,  1);
    chk("rst_a_ar_ready", a_up.ar_ready, 1);
    chk("rst_a_b_ready",  a_dn.b_ready,  1);
    chk("rst_a_r_ready",  a_dn.r_ready,  1);
    chk("rst_a_aw_valid", a_dn.aw_valid, 0);
    chk("rst_a_b_valid",  a_up.b_valid,  0);
    chk("rst_a_r_valid",  a_up.r_valid,  0);
    chk("rst_b_aw_ready_follows", b_up.aw_ready, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Single write through depth>=1 channels
    a_up.aw_valid = 1; a_up.aw_addr = 32'h100;
    a_up.w_valid = 1; a_up.w_data = 32'hDEADBEEF; a_up.w_strb = 4'hF;
    #2;
    chk("wr_aw_ready", a_up.aw_ready, 1);
    chk("wr_w_ready", a_up.w_ready, 1);
    chk("wr_no_bypass", a_dn.aw_valid, 0);
    tick();
    a_up.aw_valid = 0; a_up.w_valid = 0;
    #2;
    chk("wr_aw_valid_dn", a_dn.aw_valid, 1);
    chk("wr_aw_addr_dn", a_dn.aw_addr, 32'h100);
    chk("wr_w_valid_dn", a_dn.w_valid, 1);
    chk("wr_w_data_dn", a_dn.w_data, 32'hDEADBEEF);
    chk("wr_w_strb_dn", a_dn.w_strb, 4'hF);
    a_dn.aw_ready = 1; a_dn.w_ready = 1;
    tick();
    a_dn.aw_ready = 0; a_dn.w_ready = 0;
    a_dn.b_valid = 1; a_dn.b_resp = 2'b00;
    #2;
    chk("wr_aw_drained", a_dn.aw_valid, 0);
    chk("wr_w_drained", a_dn.w_valid, 0);
    chk("wr_b_ready_dn", a_dn.b_ready, 1);
    chk("wr_b_not_yet", a_up.b_valid, 0);
    tick();
    a_dn.b_valid = 0;
    #2;
    chk("wr_b_valid_up", a_up.b_valid, 1);
    chk("wr_b_resp_up", a_up.b_resp, 2'b00);
    a_up.b_ready = 1;
    tick();
    a_up.b_ready = 0;
    #2;
    chk("wr_b_done", a_up.b_valid, 0);
    tick();

    // Reset mid-stream with 3 beats in the AW FIFO
    for (int k = 0; k < 3; k++) begin
      a_up.aw_valid = 1; a_up.aw_addr = 32'(32'h10 * (k + 1));
      #2;
      chk("rstmid_aw_ready", a_up.aw_ready, 1);
      tick();
    end
    a_up.aw_valid = 0;
    #2;
    chk("rstmid_valid_before", a_dn.aw_valid, 1);
    chk("rstmid_addr_head", a_dn.aw_addr, 32'h10);
    rstn = 1'b0;
    #1;
    chk("rstmid_async_valid", a_dn.aw_valid, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tick();
    #2;
    chk("rstmid_no_stale", a_dn.aw_valid, 0);
    chk("rstmid_aw_ready", a_up.aw_ready, 1);
    tick();

    // Fill/drain AR FIFO (depth 3) with downstream stalled
    for (int k = 0; k < 3; k++) begin
      a_up.ar_valid = 1; a_up.ar_addr = 32'(k * 4);
      #2;
      chk("fill_ar_ready", a_up.ar_ready, 1);
      tick();
    end
    a_up.ar_valid = 0;
    #2;
    chk("full_ar_ready", a_up.ar_ready, 0);
    chk("drain_valid", a_dn.ar_valid, 1);
    chk("drain_addr", a_dn.ar_addr, 32'h0);
    a_dn.ar_ready = 1;
    tick();
    for (int k = 1; k < 3; k++) begin
      #2;
      chk("drain_valid", a_dn.ar_valid, 1);
      chk("drain_addr", a_dn.ar_addr, 32'(k * 4));
      tick();
    end
    #2;
    chk("drain_empty", a_dn.ar_valid, 0);
    idle_all();
    tick();
    reset_pulse();

    // Wrap-around stream of 10 reads through R FIFO (depth 3), random r_ready
    ar_sent = 0; ar_acc = 0; r_sent = 0; r_recv = 0;
    a_dn.ar_ready = 1;
    for (int cyc = 0; cyc < 300 && r_recv < 10; cyc++) begin
      a_up.ar_valid = (ar_sent < 10);
      a_up.ar_addr  = 32'(ar_sent * 4);
      a_dn.r_valid  = (r_sent < ar_acc);
      a_dn.r_data   = 32'(r_sent);
      a_up.r_ready  = 1'($urandom_range(0, 1));
      #2;
      hs_ar_up = a_up.ar_valid && a_up.ar_ready;
      hs_ar_dn = a_dn.ar_valid && a_dn.ar_ready;
      hs_r_dn  = a_dn.r_valid && a_dn.r_ready;
      hs_r_up  = a_up.r_valid && a_up.r_ready;
      if (hs_ar_dn) chk("wrap_ar_addr", a_dn.ar_addr, 32'(ar_acc * 4));
      if (hs_r_up)  chk("wrap_r_data", a_up.r_data, 32'(r_recv));
      tick();
      if (hs_ar_up) ar_sent++;
      if (hs_ar_dn) ar_acc++;
      if (hs_r_dn)  r_sent++;
      if (hs_r_up)  r_recv++;
    end
    chk("wrap_count", 64'(r_recv), 10);
    idle_all();
    tick();
    tick();
    reset_pulse();

    // Read outstanding limit on the wire-through instance (MAX_RD=2)
    b_dn.ar_ready = 1; b_up.r_ready = 1;
    b_up.ar_valid = 1; b_up.ar_addr = 32'h200;
    #2;
    chk("lim_ar1_ready", b_up.ar_ready, 1);
    chk("lim_ar1_pass", b_dn.ar_valid, 1);
    tick();
    b_up.ar_addr = 32'h204;
    #2;
    chk("lim_ar2_ready", b_up.ar_ready, 1);
    tick();
    b_up.ar_addr = 32'h208;
    #2;
    chk("lim_ar3_stall", b_up.ar_ready, 0);
    chk("lim_ar3_gated", b_dn.ar_valid, 0);
    tick();
    b_dn.r_valid = 1; b_dn.r_data = 32'h55;
    #2;
    chk("lim_still_stall", b_up.ar_ready, 0);
    chk("lim_r_valid_pass", b_up.r_valid, 1);
    chk("lim_r_data_pass", b_up.r_data, 32'h55);
    tick();
    b_dn.r_valid = 0;
    #2;
    chk("lim_ar3_reopen", b_up.ar_ready, 1);
    chk("lim_ar3_addr", b_dn.ar_addr, 32'h208);
    tick();
    b_up.ar_valid = 0;
    #2;
    chk("lim_at_cap_again", b_up.ar_ready, 0);
    idle_all();
    tick();
    reset_pulse();

    // Pass-through AW on the wire-through instance
    b_up.aw_valid = 1; b_up.aw_addr = 32'h40;
    #2;
    chk("pt_aw_valid", b_dn.aw_valid, 1);
    chk("pt_aw_addr", b_dn.aw_addr, 32'h40);
    chk("pt_aw_ready_low", b_up.aw_ready, 0);
    b_dn.aw_ready = 1;
    #1;
    chk("pt_aw_ready_comb", b_up.aw_ready, 1);
    tick();
    idle_all();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
